// File: rtl/tx_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tx_link_scheduler
// Description : Transmit-side lane controller. After enable it emits a burst
//               of COM training bytes, then round-robin arbitrates two byte
//               requesters onto the serializer byte input, filling idle
//               cycles with the IDLE byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_link_scheduler #(
    parameter int         COM_COUNT = 4,
    parameter logic [7:0] COM       = 8'hBC,
    parameter logic [7:0] IDLE      = 8'h7C
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in0,
    input  logic       valid_in0,
    output logic       ready_out0,
    input  logic [7:0] data_in1,
    input  logic       valid_in1,
    output logic       ready_out1,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lane_out,
    output logic       active,
    output logic [1:0] state_out
);

    localparam int            CW        = $clog2(COM_COUNT + 1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(COM_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_grant;
    logic          w_arb_en;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_xfer;

    // State register
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: TRAIN runs exactly COM_COUNT cycles; enable low always wins
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next_state = ST_TRAIN;
                end
            end
            ST_TRAIN: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Training counter: cleared in IDLE and on abort, so it can never wrap
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE:  r_cnt <= '0;
                ST_TRAIN: r_cnt <= enable ? (r_cnt + CW'(1)) : '0;
                default:  r_cnt <= r_cnt;
            endcase
        end
    end

    // Round-robin grant: a lone valid wins, a tie goes to the lane not served last
    always_comb begin
        w_arb_en = (r_state == ST_ACTIVE) && enable;
        w_grant0 = w_arb_en && valid_in0 && (!valid_in1 || r_last_grant);
        w_grant1 = w_arb_en && valid_in1 && (!valid_in0 || !r_last_grant);
        w_xfer   = w_grant0 || w_grant1;
    end

    assign ready_out0 = w_grant0;
    assign ready_out1 = w_grant1;

    // Remember the lane served last; reset value 1 lets lane 0 win the first tie
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_grant1;
        end
    end

    // Byte register follows the state being entered, so the first ACTIVE cycle
    // already carries filler and the first cycle back in IDLE carries COM
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            lane_out  <= 1'b0;
        end else if (w_next_state == ST_ACTIVE) begin
            if (w_xfer) begin
                data_out  <= w_grant1 ? data_in1 : data_in0;
                valid_out <= 1'b1;
                lane_out  <= w_grant1;
            end else begin
                data_out  <= IDLE;
                valid_out <= 1'b0;
            end
        end else begin
            data_out  <= COM;
            valid_out <= 1'b0;
        end
    end

    assign active    = (r_state == ST_ACTIVE);
    assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tx_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_link_scheduler
// Description : Directed self-checking bench for tx_link_scheduler: reset,
//               training, round-robin alternation, single-lane streaming,
//               disable and asynchronous reset during traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_link_scheduler;

    logic       clk_4f;
    logic       reset;
    logic       enable;
    logic [7:0] data_in0;
    logic       valid_in0;
    logic       ready_out0;
    logic [7:0] data_in1;
    logic       valid_in1;
    logic       ready_out1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       lane_out;
    logic       active;
    logic [1:0] state_out;

    int n_checks = 0;
    int n_fail   = 0;

    tx_link_scheduler #(
        .COM_COUNT (4),
        .COM       (8'hBC),
        .IDLE      (8'h7C)
    ) u_dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .enable     (enable),
        .data_in0   (data_in0),
        .valid_in0  (valid_in0),
        .ready_out0 (ready_out0),
        .data_in1   (data_in1),
        .valid_in1  (valid_in1),
        .ready_out1 (ready_out1),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .lane_out   (lane_out),
        .active     (active),
        .state_out  (state_out)
    );

    // 10 ns byte clock
    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data_out"},  32'(data_out),   32'h00);
        check({tag, " valid_out"}, 32'(valid_out),  32'd0);
        check({tag, " lane_out"},  32'(lane_out),   32'd0);
        check({tag, " active"},    32'(active),     32'd0);
        check({tag, " ready0"},    32'(ready_out0), 32'd0);
        check({tag, " ready1"},    32'(ready_out1), 32'd0);
        check({tag, " state"},     32'(state_out),  32'd0);
    endtask

    // Walks four TRAIN cycles; returns once the FSM has entered ACTIVE
    task automatic train_sequence(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, " train state"}, 32'(state_out), 32'd1);
            check({tag, " train data"},  32'(data_out),  32'hBC);
            check({tag, " train valid"}, 32'(valid_out), 32'd0);
            check({tag, " train ready"}, 32'({ready_out1, ready_out0}), 32'd0);
            tick();
        end
        check({tag, " active"}, 32'(active),    32'd1);
        check({tag, " state"},  32'(state_out), 32'd2);
    endtask

    logic [7:0] a_bytes [3];
    logic [7:0] b_bytes [3];
    logic [7:0] exp_rr_data [6];
    logic       exp_rr_lane [6];
    logic [7:0] one_bytes [3];

    initial begin
        int  idx0;
        int  idx1;
        logic g0;
        logic g1;

        a_bytes     = '{8'hA0, 8'hA1, 8'hA2};
        b_bytes     = '{8'hB0, 8'hB1, 8'hB2};
        exp_rr_data = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        exp_rr_lane = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        one_bytes   = '{8'h11, 8'h12, 8'h13};

        // 1: reset held low with arbitrary active inputs
        reset     = 1'b0;
        enable    = 1'b1;
        data_in0  = 8'h5A;
        valid_in0 = 1'b1;
        data_in1  = 8'hA5;
        valid_in1 = 1'b1;
        #1;
        repeat (3) tick();
        check_reset_outputs("t1");

        // 2: training then ACTIVE with filler
        reset     = 1'b1;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        tick();
        train_sequence("t2");
        check("t2 first active data",  32'(data_out),  32'h7C);
        check("t2 first active valid", 32'(valid_out), 32'd0);
        tick();
        check("t2 filler data", 32'(data_out), 32'h7C);

        // 3: both lanes loaded, strict alternation
        idx0 = 0;
        idx1 = 0;
        for (int k = 0; k < 6; k++) begin
            valid_in0 = (idx0 < 3);
            data_in0  = (idx0 < 3) ? a_bytes[idx0] : 8'h00;
            valid_in1 = (idx1 < 3);
            data_in1  = (idx1 < 3) ? b_bytes[idx1] : 8'h00;
            #1;
            check("t3 ready0", 32'(ready_out0), 32'(exp_rr_lane[k] == 1'b0));
            check("t3 ready1", 32'(ready_out1), 32'(exp_rr_lane[k] == 1'b1));
            g0 = ready_out0;
            g1 = ready_out1;
            tick();
            check("t3 data",  32'(data_out),  32'(exp_rr_data[k]));
            check("t3 valid", 32'(valid_out), 32'd1);
            check("t3 lane",  32'(lane_out),  32'(exp_rr_lane[k]));
            if (g0) idx0++;
            if (g1) idx1++;
        end
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        #1;
        check("t3 idle readys", 32'({ready_out1, ready_out0}), 32'd0);
        tick();
        check("t3 idle data",  32'(data_out),  32'h7C);
        check("t3 idle valid", 32'(valid_out), 32'd0);
        check("t3 lane holds", 32'(lane_out),  32'd1);

        // 4: only lane 1 streaming at full rate
        for (int k = 0; k < 3; k++) begin
            valid_in1 = 1'b1;
            data_in1  = one_bytes[k];
            #1;
            check("t4 ready1", 32'(ready_out1), 32'd1);
            check("t4 ready0", 32'(ready_out0), 32'd0);
            tick();
            check("t4 data",  32'(data_out),  32'(one_bytes[k]));
            check("t4 valid", 32'(valid_out), 32'd1);
            check("t4 lane",  32'(lane_out),  32'd1);
        end

        // 5: disable while both lanes request
        data_in0  = 8'h55;
        valid_in0 = 1'b1;
        data_in1  = 8'h66;
        valid_in1 = 1'b1;
        enable    = 1'b0;
        #1;
        check("t5 readys off", 32'({ready_out1, ready_out0}), 32'd0);
        check("t5 still active", 32'(state_out), 32'd2);
        tick();
        check("t5 state",  32'(state_out), 32'd0);
        check("t5 active", 32'(active),    32'd0);
        check("t5 data",   32'(data_out),  32'hBC);
        check("t5 valid",  32'(valid_out), 32'd0);

        // 6: reset mid-transfer, then full retrain with lane 0 first
        enable    = 1'b1;
        data_in0  = 8'h21;
        data_in1  = 8'h31;
        tick();
        train_sequence("t6a");
        check("t6 ready0 first", 32'(ready_out0), 32'd1);
        tick();
        check("t6 first byte", 32'(data_out), 32'h21);
        check("t6 first lane", 32'(lane_out), 32'd0);
        data_in0 = 8'h22;
        #1;
        check("t6 ready1 pending", 32'(ready_out1), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("t6 async");
        tick();
        check_reset_outputs("t6 held");
        tick();
        reset = 1'b1;
        tick();
        train_sequence("t6b");
        check("t6 ready0 after reset", 32'(ready_out0), 32'd1);
        check("t6 ready1 after reset", 32'(ready_out1), 32'd0);
        tick();
        check("t6 data after reset",  32'(data_out),  32'h22);
        check("t6 lane after reset",  32'(lane_out),  32'd0);
        check("t6 valid after reset", 32'(valid_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
